// File: rtl/mandelbrot_pkg.sv
// rtl/mandelbrot_pkg.sv - shared screen geometry, colour palette and writer state encoding
package mandelbrot_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int PIXEL_COUNT = SCREEN_W * SCREEN_H;

  localparam logic [7:0] COL_IN_SET = 8'h00;
  localparam logic [7:0] COL_BAND1  = 8'hE0;
  localparam logic [7:0] COL_BAND2  = 8'hEC;
  localparam logic [7:0] COL_BAND3  = 8'hFC;
  localparam logic [7:0] COL_BAND4  = 8'h1C;
  localparam logic [7:0] COL_BAND5  = 8'h1F;
  localparam logic [7:0] COL_BAND6  = 8'h03;
  localparam logic [7:0] COL_BAND7  = 8'h62;
  localparam logic [7:0] COL_BAND8  = 8'h01;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Bands halve the cap each step; the first threshold met from the top wins.
  function automatic logic [7:0] iter_colour(input logic [31:0] i, input logic [31:0] m);
    if (i >= m)             return COL_IN_SET;
    else if (i >= (m >> 1)) return COL_BAND1;
    else if (i >= (m >> 2)) return COL_BAND2;
    else if (i >= (m >> 3)) return COL_BAND3;
    else if (i >= (m >> 4)) return COL_BAND4;
    else if (i >= (m >> 5)) return COL_BAND5;
    else if (i >= (m >> 6)) return COL_BAND6;
    else if (i >= (m >> 7)) return COL_BAND7;
    else                    return COL_BAND8;
  endfunction

endpackage

// File: rtl/mandelbrot_pixel_writer_fifo.sv
// rtl/mandelbrot_pixel_writer_fifo.sv - synchronous FIFO buffering {addr, colour} entries
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 27
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign level   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/mandelbrot_pixel_writer.sv
// rtl/mandelbrot_pixel_writer.sv - colours iterator results and writes them to the framebuffer SRAM
module mandelbrot_pixel_writer
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH      = SCREEN_W,
  parameter int HEIGHT     = SCREEN_H,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 19
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          pix_val,
  input  logic [9:0]                    pix_x,
  input  logic [9:0]                    pix_y,
  input  logic [10:0]                   pix_iter,
  input  logic [31:0]                   max_iter,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [7:0]                    sram_data,
  output logic                          sram_we,
  input  logic                          sram_grant,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [19:0]                   pixels_written,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          overflow,
  output logic                          oob
);

  localparam int PIX_TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W     = $clog2(PIX_TOTAL + 1);
  localparam int PAY_W     = ADDR_W + 8;

  logic [1:0]        state_q, state_d;
  logic              s1_val_q, s1_val_d;
  logic              s1_oob_q, s1_oob_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [7:0]        s1_col_q, s1_col_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [19:0]       pw_q, pw_d;
  logic              ovf_q, ovf_d;
  logic              oob_q, oob_d;
  logic              done_q, done_d;

  logic              active, accept, room, s1_push_ok;
  logic              f_push, f_pop, f_full, f_empty;
  logic [PAY_W-1:0]  f_dout;
  logic [CNT_W:0]    acc_pend;
  logic [31:0]       addr_full;
  logic              coord_oob;

  assign active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign sram_we    = active && !f_empty;
  assign f_pop      = sram_we && sram_grant && !frame_start;
  assign s1_push_ok = s1_val_q && !s1_oob_q;
  assign f_push     = s1_push_ok && !frame_start;

  // Pixels still in stage 1 count against the frame so nothing beyond the last one is taken.
  assign acc_pend  = {1'b0, acc_q} + {{CNT_W{1'b0}}, s1_val_q};
  assign room      = acc_pend < (CNT_W+1)'(PIX_TOTAL);
  assign accept    = (state_q == ST_RUN) && pix_val && room && !frame_start;

  assign addr_full = 32'(pix_y) * 32'(WIDTH) + 32'(pix_x);
  assign coord_oob = (32'(pix_x) >= 32'(WIDTH)) || (32'(pix_y) >= 32'(HEIGHT));

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (frame_start),
    .push  (f_push),
    .pop   (f_pop),
    .din   ({s1_addr_q, s1_col_q}),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    s1_val_d  = accept;
    s1_oob_d  = s1_oob_q;
    s1_addr_d = s1_addr_q;
    s1_col_d  = s1_col_q;
    acc_d     = acc_q + {{(CNT_W-1){1'b0}}, s1_val_q};
    pw_d      = pw_q;
    ovf_d     = ovf_q | (s1_push_ok && f_full && !f_pop);
    oob_d     = oob_q | (s1_val_q && s1_oob_q);
    done_d    = 1'b0;

    if (accept) begin
      s1_oob_d  = coord_oob;
      s1_addr_d = addr_full[ADDR_W-1:0];
      s1_col_d  = iter_colour({21'b0, pix_iter}, max_iter);
    end

    if (f_pop && (pw_q != '1)) pw_d = pw_q + 20'd1;

    case (state_q)
      ST_RUN: begin
        if (acc_q == CNT_W'(PIX_TOTAL)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (f_empty && !s1_val_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase

    // A new frame overrides everything else happening this cycle.
    if (frame_start) begin
      state_d  = ST_RUN;
      s1_val_d = 1'b0;
      acc_d    = '0;
      pw_d     = '0;
      ovf_d    = 1'b0;
      oob_d    = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s1_val_q  <= 1'b0;
      s1_oob_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_col_q  <= '0;
      acc_q     <= '0;
      pw_q      <= '0;
      ovf_q     <= 1'b0;
      oob_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_val_q  <= s1_val_d;
      s1_oob_q  <= s1_oob_d;
      s1_addr_q <= s1_addr_d;
      s1_col_q  <= s1_col_d;
      acc_q     <= acc_d;
      pw_q      <= pw_d;
      ovf_q     <= ovf_d;
      oob_q     <= oob_d;
      done_q    <= done_d;
    end
  end

  assign sram_addr      = sram_we ? f_dout[PAY_W-1:8] : '0;
  assign sram_data      = sram_we ? f_dout[7:0] : 8'h00;
  assign pixels_written = pw_q;
  assign frame_done     = done_q;
  assign busy           = active;
  assign overflow       = ovf_q;
  assign oob            = oob_q;

endmodule

// File: tb/tb_mandelbrot_pixel_writer.sv
// tb/tb_mandelbrot_pixel_writer.sv - scoreboard bench for mandelbrot_pixel_writer
module tb_mandelbrot_pixel_writer;

  logic        clk = 1'b0;
  logic        reset, frame_start, pix_val_a, pix_val_b, sram_grant;
  logic [9:0]  pix_x, pix_y;
  logic [10:0] pix_iter;
  logic [31:0] max_iter;

  logic [18:0] a_addr, b_addr;
  logic [7:0]  a_data, b_data;
  logic        a_we, b_we, a_done, b_done, a_busy, b_busy, a_ovf, b_ovf, a_oob, b_oob;
  logic [4:0]  a_level, b_level;
  logic [19:0] a_pw, b_pw;

  int tests = 0;
  int fails = 0;
  int wr_a = 0;
  int wr_b = 0;
  int done_b = 0;
  logic [26:0] exp_a[$];
  logic [26:0] exp_b[$];

  always #5 clk = ~clk;

  mandelbrot_pixel_writer dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_val(pix_val_a),
    .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter), .max_iter(max_iter),
    .sram_addr(a_addr), .sram_data(a_data), .sram_we(a_we), .sram_grant(sram_grant),
    .fifo_level(a_level), .pixels_written(a_pw), .frame_done(a_done), .busy(a_busy),
    .overflow(a_ovf), .oob(a_oob)
  );

  mandelbrot_pixel_writer #(.WIDTH(4), .HEIGHT(2)) dut_b (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_val(pix_val_b),
    .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter), .max_iter(max_iter),
    .sram_addr(b_addr), .sram_data(b_data), .sram_we(b_we), .sram_grant(sram_grant),
    .fifo_level(b_level), .pixels_written(b_pw), .frame_done(b_done), .busy(b_busy),
    .overflow(b_ovf), .oob(b_oob)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && a_we && sram_grant) begin
      if (exp_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_write: got addr 0x%0h data 0x%0h, expected no write", a_addr, a_data);
      end else begin
        check("a_write", {5'b0, a_addr, a_data}, {5'b0, exp_a.pop_front()});
      end
      wr_a++;
    end
    if (!reset && b_we && sram_grant) begin
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_write: got addr 0x%0h data 0x%0h, expected no write", b_addr, b_data);
      end else begin
        check("b_write", {5'b0, b_addr, b_data}, {5'b0, exp_b.pop_front()});
      end
      wr_b++;
    end
    if (!reset && b_done) begin
      done_b++;
      check("b_done_after_8_writes", 32'(wr_b), 32'd8);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic send_a(input int x, input int y, input int it);
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_iter  = 11'(it);
    pix_val_a = 1'b1;
    tick(1);
    pix_val_a = 1'b0;
  endtask

  initial begin
    #300000;
    fails++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int its[8];
    logic [7:0] cols[8];
    int base;

    its  = '{600, 300, 130, 70, 40, 20, 10, 2};
    cols = '{8'hE0, 8'hEC, 8'hFC, 8'h1C, 8'h1F, 8'h03, 8'h62, 8'h01};

    reset = 1'b1; frame_start = 1'b0; pix_val_a = 1'b0; pix_val_b = 1'b0;
    sram_grant = 1'b0; pix_x = '0; pix_y = '0; pix_iter = '0; max_iter = 32'd1000;
    tick(3);
    check("reset_we_level", {26'b0, a_we, a_level}, 32'd0);
    check("reset_addr_data", {5'b0, a_addr, a_data}, 32'd0);
    check("reset_flags", {27'b0, a_done, a_busy, a_ovf, a_oob, b_busy}, 32'd0);
    check("reset_pw", 32'(a_pw), 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: latency and first write
    start_frame();
    sram_grant = 1'b1;
    exp_a.push_back({19'd1283, 8'h00});
    send_a(3, 2, 1000);
    check("t1_we_after_1", 32'(a_we), 32'd0);
    tick(1);
    check("t1_we_after_2", 32'(a_we), 32'd1);
    check("t1_addr", 32'(a_addr), 32'd1283);
    check("t1_data", 32'(a_data), 32'h00);
    tick(1);
    check("t1_pw", 32'(a_pw), 32'd1);
    check("t1_busy", 32'(a_busy), 32'd1);

    // 2: colour bands
    for (int k = 0; k < 8; k++) begin
      exp_a.push_back({19'(4480 + k), cols[k]});
      send_a(k, 7, its[k]);
    end
    tick(6);
    check("t2_queue_drained", 32'(exp_a.size()), 32'd0);
    check("t2_pw", 32'(a_pw), 32'd9);

    // 3: overflow with grant held low
    start_frame();
    sram_grant = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k < 16) exp_a.push_back({19'(3200 + k), 8'h00});
      send_a(k, 5, 1000);
    end
    tick(3);
    check("t3_level_full", 32'(a_level), 32'd16);
    check("t3_overflow", 32'(a_ovf), 32'd1);
    check("t3_head_addr", 32'(a_addr), 32'd3200);
    tick(2);
    check("t3_head_held", {5'b0, a_addr, a_data}, {5'b0, 19'd3200, 8'h00});
    base = wr_a;
    sram_grant = 1'b1;
    tick(8);
    check("t3_one_per_cycle", 32'(wr_a - base), 32'd8);
    tick(12);
    check("t3_writes", 32'(wr_a - base), 32'd16);
    check("t3_level_empty", 32'(a_level), 32'd0);
    check("t3_overflow_sticky", 32'(a_ovf), 32'd1);
    check("t3_pw", 32'(a_pw), 32'd16);

    // 4: out-of-range column
    base = wr_a;
    send_a(640, 0, 1000);
    tick(3);
    check("t4_oob", 32'(a_oob), 32'd1);
    check("t4_level", 32'(a_level), 32'd0);
    check("t4_no_write", 32'(wr_a - base), 32'd0);
    start_frame();
    check("t4_oob_cleared", 32'(a_oob), 32'd0);
    check("t4_ovf_cleared", 32'(a_ovf), 32'd0);
    check("t4_pw_cleared", 32'(a_pw), 32'd0);

    // 5: small frame on the 4x2 instance, grant toggling
    start_frame();
    for (int cyc = 0; cyc < 40; cyc++) begin
      sram_grant = cyc[0];
      if (cyc < 8) begin
        pix_x     = 10'(cyc % 4);
        pix_y     = 10'(cyc / 4);
        pix_iter  = 11'd2;
        pix_val_b = 1'b1;
        exp_b.push_back({19'((cyc / 4) * 4 + (cyc % 4)), 8'h01});
      end else begin
        pix_val_b = 1'b0;
      end
      if (cyc == 4) check("t5_busy_running", 32'(b_busy), 32'd1);
      tick(1);
    end
    check("t5_writes", 32'(wr_b), 32'd8);
    check("t5_done_once", 32'(done_b), 32'd1);
    check("t5_idle_after_done", 32'(b_busy), 32'd0);
    check("t5_pw", 32'(b_pw), 32'd8);
    pix_x = '0; pix_y = '0; pix_val_b = 1'b1;
    tick(1);
    pix_val_b = 1'b0;
    tick(5);
    check("t5_ninth_ignored", 32'(wr_b), 32'd8);
    check("t5_ninth_level", 32'(b_level), 32'd0);
    check("t5_done_still_once", 32'(done_b), 32'd1);

    // 6: asynchronous reset with writes pending
    start_frame();
    sram_grant = 1'b0;
    for (int k = 0; k < 5; k++) send_a(k, 1, 1000);
    tick(3);
    check("t6_level_before", 32'(a_level), 32'd5);
    check("t6_we_before", 32'(a_we), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("t6_we_dropped", 32'(a_we), 32'd0);
    check("t6_level_cleared", 32'(a_level), 32'd0);
    tick(1);
    reset = 1'b0;
    sram_grant = 1'b1;
    base = wr_a;
    send_a(1, 1, 1000);
    tick(10);
    check("t6_no_writes", 32'(wr_a - base), 32'd0);
    check("t6_level_idle", 32'(a_level), 32'd0);
    check("t6_pw", 32'(a_pw), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
